// File: rtl/fetch_pkg.sv
// Shared constants and types for the 16-bit MIPS instruction fetch unit.
// FSM state encodings, bus widths and reset values.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_PC_INC  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [FETCH_ADDR_W-1:0]  ADDR_RST  = '0;
  localparam logic [FETCH_INSTR_W-1:0] INSTR_RST = '0;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction-memory req/ack channel plus the
// valid/ready channel towards decode.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready holding register between fetch and decode.
// Flush beats load beats fire; load during fire keeps full throughput.
module fetch_out_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               fire_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    unique case (1'b1)
      flush_i: valid_d = 1'b0;
      load_i: begin
        valid_d = 1'b1;
        instr_d = data_i;
        pc_d    = pc_i;
      end
      fire_i:  valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_W'(INSTR_RST);
      pc_q    <= ADDR_W'(ADDR_RST);
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives the PC, issues imem requests,
// handles redirects (draining an in-flight request) and feeds decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int PC_INC  = FETCH_PC_INC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  fetch_unit_if.master      bus
);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic               ack;
  logic               fire;
  logic               buf_load;
  logic               buf_valid;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  buf_pc;
  logic [ADDR_W-1:0]  pc_inc;

  // An ack with no request outstanding is a protocol error and is dropped.
  assign ack    = req_q & bus.imem_ack;
  assign fire   = buf_valid & bus.instr_ready;
  assign pc_inc = pc_cur + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= ADDR_W'(ADDR_RST);
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid) state_d = REQ;
      end
      REQ: begin
        if (redirect_valid)
          state_d = (req_q && !ack) ? DRAIN : IDLE;
        else if (!req_q && buf_valid && !bus.instr_ready)
          state_d = STALL;
      end
      STALL: begin
        if (redirect_valid) state_d = IDLE;
        else if (fire)      state_d = REQ;
      end
      DRAIN: begin
        if (redirect_valid) state_d = ack ? IDLE : DRAIN;
        else if (ack)       state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d    = 1'b0;
    addr_d   = addr_q;
    buf_load = 1'b0;
    pc_next  = pc_cur;
    if (!rst) begin
      if (redirect_valid)
        pc_next = redirect_target;
      else if (state_q == REQ && ack)
        pc_next = pc_inc;
    end
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid) begin
          req_d  = 1'b1;
          addr_d = pc_cur;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          req_d = req_q && !ack;
        end else if (req_q) begin
          // Accepted ack: one idle cycle, then fetch the next word.
          req_d    = !ack;
          buf_load = ack;
          if (ack) addr_d = pc_inc;
        end else begin
          req_d = !(buf_valid && !bus.instr_ready);
        end
      end
      STALL: begin
        if (!redirect_valid && fire) begin
          req_d  = 1'b1;
          addr_d = pc_cur;
        end
      end
      DRAIN: begin
        req_d = !ack;
        if (!redirect_valid && ack) addr_d = pc_cur;
      end
      default: ;
    endcase
  end

  fetch_out_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .fire_i  (fire),
    .flush_i (redirect_valid),
    .data_i  (bus.imem_rdata),
    .pc_i    (addr_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = buf_valid;
  assign bus.instr       = buf_instr;
  assign bus.instr_pc    = buf_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register model and
// hand-sequenced memory acks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0;

  int checks   = 0;
  int failures = 0;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) pc_cur <= 16'h0;
    else     pc_cur <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] an;
    an = a + 16'd1;
    nxt();
    bus.imem_ack = 1'b0;
    #1;
    chk("issue_req", bus.imem_req, 1);
    chk("issue_addr", bus.imem_addr, a);
    chk("issue_pc_hold", pc_next, a);
    nxt();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    #1;
    chk("ack_pc_inc", pc_next, an);
    nxt();
    bus.imem_ack = 1'b0;
    #1;
    chk("gap_req", bus.imem_req, 0);
    chk("gap_valid", bus.instr_valid, 1);
    chk("gap_instr", bus.instr, d);
    chk("gap_instr_pc", bus.instr_pc, a);
    chk("gap_pc_hold", pc_next, an);
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.instr_ready = 1'b1;

    // reset state
    nxt();
    nxt();
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_pc_hold", pc_next, 0);

    nxt();
    rst = 1'b0;
    #1;
    chk("idle_req", bus.imem_req, 0);

    // sequential fetch 0..3
    for (int i = 0; i < 4; i++)
      fetch_one(16'(i), 16'hA000 + 16'(i));

    // reset in the middle of the request to 4
    nxt();
    rst = 1'b1;
    #1;
    chk("mid_req", bus.imem_req, 1);
    chk("mid_addr", bus.imem_addr, 16'h4);
    nxt();
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    chk("mrst_req", bus.imem_req, 0);
    chk("mrst_addr", bus.imem_addr, 0);
    chk("mrst_valid", bus.instr_valid, 0);
    chk("mrst_instr", bus.instr, 0);
    chk("mrst_instr_pc", bus.instr_pc, 0);
    chk("mrst_pc", pc_next, 0);

    // restart at 0, decode stalls
    fetch_one(16'h0, 16'hB000);
    for (int i = 0; i < 10; i++) begin
      nxt();
      bus.imem_ack = (i == 5);
      #1;
      chk("stall_req", bus.imem_req, 0);
      chk("stall_pc_cur", pc_cur, 16'h1);
      chk("stall_pc_next", pc_next, 16'h1);
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_instr", bus.instr, 16'hB000);
    end
    nxt();
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("unstall_fire", bus.instr_valid, 1);
    for (int i = 1; i < 5; i++)
      fetch_one(16'(i), 16'hC000 + 16'(i));

    // redirect while request to 5 is outstanding, ack 3 cycles later
    nxt();
    redirect_valid  = 1'b1;
    redirect_target = 16'h0040;
    #1;
    chk("rd_req", bus.imem_req, 1);
    chk("rd_addr", bus.imem_addr, 16'h5);
    chk("rd_pc_next", pc_next, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      nxt();
      redirect_valid = 1'b0;
      bus.imem_ack   = (i == 2);
      bus.imem_rdata = 16'hDEAD;
      #1;
      chk("drain_req", bus.imem_req, 1);
      chk("drain_addr", bus.imem_addr, 16'h5);
      chk("drain_valid", bus.instr_valid, 0);
      chk("drain_pc_next", pc_next, 16'h0040);
    end
    nxt();
    bus.imem_ack = 1'b0;
    #1;
    chk("post_drain_req", bus.imem_req, 0);
    chk("post_drain_addr", bus.imem_addr, 16'h0040);
    chk("post_drain_valid", bus.instr_valid, 0);
    fetch_one(16'h0040, 16'hD040);

    // redirect coincident with ack
    nxt();
    #1;
    chk("co_req", bus.imem_req, 1);
    chk("co_addr", bus.imem_addr, 16'h0041);
    nxt();
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 16'hEEEE;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0080;
    #1;
    chk("co_pc_next", pc_next, 16'h0080);
    nxt();
    bus.imem_ack   = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("co_idle_req", bus.imem_req, 0);
    chk("co_idle_valid", bus.instr_valid, 0);
    chk("co_idle_pc", pc_next, 16'h0080);
    fetch_one(16'h0080, 16'hE080);

    // redirect to 16'hFFFF then wrap to 0
    nxt();
    redirect_valid  = 1'b1;
    redirect_target = 16'hFFFF;
    #1;
    chk("wr_pc_next", pc_next, 16'hFFFF);
    nxt();
    redirect_valid = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h1111;
    #1;
    chk("wr_drain_addr", bus.imem_addr, 16'h0081);
    chk("wr_drain_pc", pc_next, 16'hFFFF);
    nxt();
    bus.imem_ack = 1'b0;
    #1;
    chk("wr_gap_req", bus.imem_req, 0);
    chk("wr_gap_valid", bus.instr_valid, 0);
    fetch_one(16'hFFFF, 16'hF0FF);
    fetch_one(16'h0000, 16'hF000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
